alu_operand_loader: RTL
=======================

// Module: alu_operand_loader
// PURPOSE
//  Front end that drives the ALU core. It collects operand A, operand B and the opcode
//  from the 8 input switches, using a debounced LOAD button. It then issues the command
//  to the ALU with a valid/ready handshake, waits for the ALU result and holds it for
//  the display. It sits between the top-level ui_in/uio_in pins and the ALU datapath.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive stable synchronized samples needed before a button level is accepted
//  TIMEOUT_CYCLES   255  max cycles in WAIT before the result is declared missing (>=1)
// PORTS
//  clk           in   1  clock
//  rst_n         in   1  reset, synchronous, active-low
//  ena           in   1  design enable; low = freeze all state, ignore buttons
//  sw_in         in   8  switch value to capture
//  load_btn      in   1  raw async LOAD button (active-high)
//  abort_btn     in   1  raw async ABORT button (active-high)
//  op_a          out  8  captured operand A
//  op_b          out  8  captured operand B
//  opcode        out  4  captured opcode (sw_in[3:0])
//  issue_valid   out  1  command valid to ALU
//  issue_ready   in   1  ALU accepts command
//  result_valid  in   1  ALU result strobe (1 cycle)
//  result        in   8  ALU result
//  disp_data     out  8  value for display
//  phase         out  3  current FSM state code
//  err           out  1  timeout occurred (sticky until next LOAD in SHOW, ABORT or reset)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - op_a, op_b, opcode, disp_data = 0; issue_valid = 0; err = 0.
//   - State = S_A; debouncers and synchronizers cleared to 0.
//  Button path:
//   - 2-flop synchronizer, then debounce. The debounced level changes only after
//     DEBOUNCE_CYCLES identical samples.
//   - load_pulse = 1-cycle pulse on the debounced 0->1 edge of LOAD.
//   - abort_pulse = the same, derived from ABORT.
//   - Latency from the raw edge to the pulse is 2+DEBOUNCE_CYCLES cycles.
//   - Holding a button yields exactly one pulse.
//  ena=0: all registers hold; pulses occurring while ena=0 are discarded (debouncers keep running).
//  FSM (phase codes 0..5):
//   S_A:     load_pulse -> op_a<=sw_in, disp_data<=sw_in, go S_B.
//   S_B:     load_pulse -> op_b<=sw_in, disp_data<=sw_in, go S_OP.
//   S_OP:    load_pulse -> opcode<=sw_in[3:0], go S_ISSUE. issue_valid=1 from the next cycle.
//   S_ISSUE: issue_valid held high; op_a/op_b/opcode stable.
//            issue_valid&issue_ready -> issue_valid<=0, timeout counter<=0, go S_WAIT.
//   S_WAIT:  result_valid -> disp_data<=result, go S_SHOW.
//            Else counter++. When the counter reaches TIMEOUT_CYCLES: err<=1, disp_data<=8'hEE, go S_SHOW.
//            result_valid on the same cycle as the timeout: the result wins, err stays 0.
//   S_SHOW:  load_pulse -> err<=0, op_a<=sw_in, disp_data<=sw_in, go S_B. This is a fast restart.
//  Events outside their states are ignored:
//   - load_pulse in S_ISSUE/S_WAIT.
//   - result_valid outside S_WAIT.
//  ABORT:
//   - abort_pulse in any state -> go S_A; issue_valid<=0, err<=0, disp_data<=0; operands keep their values.
//   - ABORT has priority over a coincident load_pulse, handshake or result.
//   - An abort on the same cycle as an issue handshake cancels the issue from the loader's view.
//  rst_n low mid-operation: all state returns to the reset values at that edge, regardless of state.
// STRUCTURE
//  Package alu_loader_pkg:
//   - state enum (S_A..S_SHOW, 3 bits).
//   - OPCODE_W=4, DATA_W=8.
//   - ERR_DISP=8'hEE.
//  Sub-module btn_debounce (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES).
//   - Instantiated twice, for LOAD and ABORT.
//  FSM and capture registers stay in this module.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
//  1. Full transaction.
//     Stimulus: sw_in=8'h12, LOAD; then 8'h34, LOAD; then 8'h03, LOAD; ALU returns 8'h46 two cycles after ready.
//     Required: op_a=12, op_b=34, opcode=3; issue_valid holds until ready; disp_data=46; phase=S_SHOW; err=0.
//  2. Bounce.
//     Stimulus: LOAD toggles every cycle for 10 cycles, then stays high for 8 cycles.
//     Required: exactly one load_pulse; only op_a is captured.
//  3. Backpressure.
//     Stimulus: issue_ready stays low for 20 cycles.
//     Required: issue_valid=1 and operands stable throughout; handshake on the first ready cycle; S_WAIT follows.
//  4. Timeout.
//     Stimulus: no result_valid.
//     Required: after 16 cycles in S_WAIT, err=1, disp_data=EE, phase=S_SHOW. The next LOAD clears err.
//  5. Abort and enable.
//     Stimulus: ABORT during S_ISSUE.
//     Required: issue_valid drops; phase=S_A.
//     Stimulus: ena=0 while a LOAD pulse fires.
//     Required: no capture, state frozen.
//  6. Reset.
//     Stimulus: rst_n low for 1 cycle during S_WAIT.
//     Required: all outputs at reset values; phase=S_A.

Source files
------------

// File: rtl/alu_loader_pkg.sv
// Shared types and constants for the ALU operand loader.
//   state_t  : loader FSM states; the numeric code is exported as the phase output
//   DATA_W   : operand / result / display width
//   OPCODE_W : opcode width taken from the low switch bits
//   ERR_DISP : display value shown when the ALU result never arrives
package alu_loader_pkg;

  localparam int DATA_W   = 8;
  localparam int OPCODE_W = 4;

  localparam logic [DATA_W-1:0] ERR_DISP = 8'hEE;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_OP    = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_SHOW  = 3'd5
  } state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Command/result bus between the operand loader and the ALU core.
//   op_a, op_b, opcode : operands and opcode, stable while issue_valid is high
//   issue_valid        : loader offers a command
//   issue_ready        : ALU accepts the command (handshake when both are high)
//   result_valid       : one-cycle strobe qualifying result
//   result             : ALU result
// master = loader side, slave = ALU side.
interface alu_operand_loader_if;
  import alu_loader_pkg::*;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [OPCODE_W-1:0] opcode;
  logic                issue_valid;
  logic                issue_ready;
  logic                result_valid;
  logic [DATA_W-1:0]   result;

  modport master (
    output op_a, op_b, opcode, issue_valid,
    input  issue_ready, result_valid, result
  );

  modport slave (
    input  op_a, op_b, opcode, issue_valid,
    output issue_ready, result_valid, result
  );

endinterface

// File: rtl/alu_operand_loader_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer and rising-edge pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   btn_raw    : asynchronous raw button level
//   pulse      : one-cycle pulse when the debounced level goes 0->1
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      // stage p0/p1: metastability synchronizer
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      // debounce stage: count disagreeing samples, flip level on the last one
      pulse   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
        pulse <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// ALU front end: captures operand A, operand B and opcode from the switches on
// debounced LOAD presses, issues the command over a valid/ready handshake, waits
// (with timeout) for the result and holds it for the display.
//   clk, rst_n  : clock, synchronous active-low reset
//   ena         : low freezes all loader state and drops button pulses
//   sw_in       : switch value to capture
//   load_btn    : raw LOAD button
//   abort_btn   : raw ABORT button, returns to S_A from any state
//   alu         : command/result bus (master side)
//   disp_data   : value for the display
//   phase       : current FSM state code
//   err         : sticky result-timeout flag
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W-1:0]   sw_in,
  input  logic                load_btn,
  input  logic                abort_btn,
  alu_operand_loader_if.master alu,
  output logic [DATA_W-1:0]   disp_data,
  output logic [2:0]          phase,
  output logic                err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             load_pulse;
  logic             abort_pulse;
  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;

  // The debouncers run even when ena is low, so a press made while frozen is
  // consumed and lost rather than replayed once ena returns.
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (load_btn),
    .pulse   (load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (abort_btn),
    .pulse   (abort_pulse)
  );

  assign phase = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_A;
      alu.op_a        <= '0;
      alu.op_b        <= '0;
      alu.opcode      <= '0;
      alu.issue_valid <= 1'b0;
      disp_data       <= '0;
      err             <= 1'b0;
      tmo_cnt         <= '0;
    end else if (ena) begin
      // Abort outranks every other event, including a same-cycle handshake:
      // the loader then treats the command as never issued.
      if (abort_pulse) begin
        state           <= S_A;
        alu.issue_valid <= 1'b0;
        err             <= 1'b0;
        disp_data       <= '0;
      end else begin
        case (state)
          S_A: begin
            if (load_pulse) begin
              alu.op_a  <= sw_in;
              disp_data <= sw_in;
              state     <= S_B;
            end
          end
          S_B: begin
            if (load_pulse) begin
              alu.op_b  <= sw_in;
              disp_data <= sw_in;
              state     <= S_OP;
            end
          end
          S_OP: begin
            if (load_pulse) begin
              alu.opcode      <= sw_in[OPCODE_W-1:0];
              alu.issue_valid <= 1'b1;
              state           <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // issue_valid is always high here, so ready alone completes the handshake
            if (alu.issue_ready) begin
              alu.issue_valid <= 1'b0;
              tmo_cnt         <= '0;
              state           <= S_WAIT;
            end
          end
          S_WAIT: begin
            // A result on the final timeout cycle still counts as a good result.
            if (alu.result_valid) begin
              disp_data <= alu.result;
              state     <= S_SHOW;
            end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              err       <= 1'b1;
              disp_data <= ERR_DISP;
              state     <= S_SHOW;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          S_SHOW: begin
            // LOAD here restarts directly with a new operand A.
            if (load_pulse) begin
              err       <= 1'b0;
              alu.op_a  <= sw_in;
              disp_data <= sw_in;
              state     <= S_B;
            end
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule
